// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage: OTTER RV32I instruction fetch with a one-entry skid buffer and flush-on-redirect.
// Optional build macro FETCH_STATS_EN adds FETCH_COUNT / BUBBLE_COUNT statistics outputs.
module otter_fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_READ,
   input  logic [31:0] IMEM_DOUT,
   input  logic        STALL,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   output logic [31:0] DEC_IR,
   output logic [31:0] DEC_PC,
   output logic        DEC_VALID
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] FETCH_COUNT,
   output logic [31:0] BUBBLE_COUNT
`endif
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   logic [0:0]  state_q,     state_d;
   logic [31:0] fetchPc_q,   fetchPc_d;
   logic        inflValid_q, inflValid_d;
   logic [31:0] inflPc_q,    inflPc_d;
   logic        skidValid_q, skidValid_d;
   logic [31:0] skidIr_q,    skidIr_d;
   logic [31:0] skidPc_q,    skidPc_d;
   logic [31:0] decIr_q,     decIr_d;
   logic [31:0] decPc_q,     decPc_d;
   logic        decValid_q,  decValid_d;

   logic [31:0] redirectAligned;
   logic [31:0] fetchAligned;
   logic        loadNew;
   logic        loadBubble;

   assign redirectAligned = REDIRECT_PC & WORD_MASK;
   assign fetchAligned    = fetchPc_q & WORD_MASK;

   // A request goes out whenever decode can take data next cycle, or a redirect
   // restarts the stream; during a stall the memory port is left idle.
   always_comb begin
      IMEM_READ = 1'b0;
      IMEM_ADDR = fetchAligned;
      if (REDIRECT) begin
         IMEM_ADDR = redirectAligned;
      end
      if (!RST) begin
         IMEM_READ = REDIRECT | ~STALL;
      end
   end

   // Next-state logic. Redirect wins over stall and flushes both the decode
   // registers and the skid buffer; the word returned for the target arrives one
   // cycle later, giving a single bubble.
   always_comb begin
      state_d     = state_q;
      fetchPc_d   = fetchPc_q;
      inflValid_d = inflValid_q;
      inflPc_d    = inflPc_q;
      skidValid_d = skidValid_q;
      skidIr_d    = skidIr_q;
      skidPc_d    = skidPc_q;
      decIr_d     = decIr_q;
      decPc_d     = decPc_q;
      decValid_d  = decValid_q;
      loadNew     = 1'b0;
      loadBubble  = 1'b0;

      if (REDIRECT) begin
         decValid_d  = 1'b0;
         decIr_d     = NOP_INSTR;
         skidValid_d = 1'b0;
         inflValid_d = 1'b1;
         inflPc_d    = redirectAligned;
         fetchPc_d   = redirectAligned + 32'd4;
         state_d     = ST_RUN;
         loadBubble  = 1'b1;
      end else if (state_q == ST_RUN) begin
         if (!STALL) begin
            decIr_d     = inflValid_q ? IMEM_DOUT : NOP_INSTR;
            decPc_d     = inflPc_q;
            decValid_d  = inflValid_q;
            inflValid_d = 1'b1;
            inflPc_d    = fetchAligned;
            fetchPc_d   = fetchAligned + 32'd4;
            loadNew     = inflValid_q;
            loadBubble  = ~inflValid_q;
         end else begin
            // The word already in flight cannot be refused by the memory, so it
            // is parked in the skid buffer until decode frees up.
            if (inflValid_q) begin
               skidIr_d    = IMEM_DOUT;
               skidPc_d    = inflPc_q;
               skidValid_d = 1'b1;
               state_d     = ST_HOLD;
            end
            inflValid_d = 1'b0;
         end
      end else begin
         if (!STALL) begin
            decIr_d     = skidIr_q;
            decPc_d     = skidPc_q;
            decValid_d  = 1'b1;
            skidValid_d = 1'b0;
            inflValid_d = 1'b1;
            inflPc_d    = fetchAligned;
            fetchPc_d   = fetchAligned + 32'd4;
            state_d     = ST_RUN;
            loadNew     = 1'b1;
         end
      end
   end

   // All pipeline state; the skid contents are discarded by reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_RUN;
         fetchPc_q   <= RESET_VECTOR;
         inflValid_q <= 1'b0;
         inflPc_q    <= 32'h0000_0000;
         skidValid_q <= 1'b0;
         skidIr_q    <= NOP_INSTR;
         skidPc_q    <= 32'h0000_0000;
         decIr_q     <= NOP_INSTR;
         decPc_q     <= 32'h0000_0000;
         decValid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetchPc_q   <= fetchPc_d;
         inflValid_q <= inflValid_d;
         inflPc_q    <= inflPc_d;
         skidValid_q <= skidValid_d;
         skidIr_q    <= skidIr_d;
         skidPc_q    <= skidPc_d;
         decIr_q     <= decIr_d;
         decPc_q     <= decPc_d;
         decValid_q  <= decValid_d;
      end
   end

   assign DEC_IR    = decIr_q;
   assign DEC_PC    = decPc_q;
   assign DEC_VALID = decValid_q;

`ifdef FETCH_STATS_EN
   logic [31:0] fetchCount_q;
   logic [31:0] bubbleCount_q;

   // Held decode contents during a stall count as neither fetch nor bubble.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetchCount_q  <= 32'h0000_0000;
         bubbleCount_q <= 32'h0000_0000;
      end else begin
         if (loadNew) begin
            fetchCount_q <= fetchCount_q + 32'd1;
         end
         if (loadBubble) begin
            bubbleCount_q <= bubbleCount_q + 32'd1;
         end
      end
   end

   assign FETCH_COUNT  = fetchCount_q;
   assign BUBBLE_COUNT = bubbleCount_q;
`else
   logic unusedStats;
   assign unusedStats = loadNew ^ loadBubble ^ skidValid_q;
`endif

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed scoreboard bench for otter_fetch_stage: streaming, stall/skid, redirect, reset-vector wrap.
// Build with FETCH_STATS_EN defined to also check the statistics counters.
module tb_otter_fetch_stage;

   typedef struct {
      logic        valid;
      logic        chkPc;
      logic [31:0] ir;
      logic [31:0] pc;
      int          kind;
   } decExp_t;

   localparam int KIND_BUBBLE = 0;
   localparam int KIND_NEW    = 1;
   localparam int KIND_HOLD   = 2;

   logic        CLK;
   logic        RST;
   logic        STALL;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;

   logic [31:0] imemAddr,  imemAddr2;
   logic        imemRead,  imemRead2;
   logic [31:0] imemDout,  imemDout2;
   logic [31:0] decIr,     decIr2;
   logic [31:0] decPc,     decPc2;
   logic        decValid,  decValid2;
   logic        zeroBit;
   logic [31:0] zeroWord;
`ifdef FETCH_STATS_EN
   logic [31:0] fetchCount,  fetchCount2;
   logic [31:0] bubbleCount, bubbleCount2;
`endif

   int      vectors     = 0;
   int      miscompares = 0;
   int      expFetch    = 0;
   int      expBubble   = 0;
   decExp_t sb[$];

   assign zeroBit  = 1'b0;
   assign zeroWord = 32'h0000_0000;

   otter_fetch_stage dut (
      .CLK(CLK), .RST(RST),
      .IMEM_ADDR(imemAddr), .IMEM_READ(imemRead), .IMEM_DOUT(imemDout),
      .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
      .DEC_IR(decIr), .DEC_PC(decPc), .DEC_VALID(decValid)
`ifdef FETCH_STATS_EN
      , .FETCH_COUNT(fetchCount), .BUBBLE_COUNT(bubbleCount)
`endif
   );

   otter_fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
      .CLK(CLK), .RST(RST),
      .IMEM_ADDR(imemAddr2), .IMEM_READ(imemRead2), .IMEM_DOUT(imemDout2),
      .STALL(zeroBit), .REDIRECT(zeroBit), .REDIRECT_PC(zeroWord),
      .DEC_IR(decIr2), .DEC_PC(decPc2), .DEC_VALID(decValid2)
`ifdef FETCH_STATS_EN
      , .FETCH_COUNT(fetchCount2), .BUBBLE_COUNT(bubbleCount2)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   // Synchronous-read instruction memories; idle cycles return garbage.
   always @(posedge CLK) begin
      imemDout  <= imemRead  ? memWord(imemAddr)  : 32'hDEAD_BEEF;
      imemDout2 <= imemRead2 ? memWord(imemAddr2) : 32'hDEAD_BEEF;
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expectBubble(input logic chkPc, input logic [31:0] pc);
      decExp_t e;
      e.valid = 1'b0; e.chkPc = chkPc; e.ir = 32'h0000_0013; e.pc = pc; e.kind = KIND_BUBBLE;
      sb.push_back(e);
   endtask

   task automatic expectWord(input logic [31:0] pc, input int kind);
      decExp_t e;
      e.valid = 1'b1; e.chkPc = 1'b1; e.ir = memWord(pc); e.pc = pc; e.kind = kind;
      sb.push_back(e);
   endtask

   // One clock edge, then the oldest scoreboard entry is compared with DEC_*.
   task automatic tick(input string tag);
      decExp_t e;
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
         checkVal({tag, "_sbEmpty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         if (e.kind == KIND_NEW)    expFetch++;
         if (e.kind == KIND_BUBBLE) expBubble++;
         checkVal({tag, "_valid"}, {31'd0, decValid}, {31'd0, e.valid});
         checkVal({tag, "_ir"}, decIr, e.ir);
         if (e.chkPc) checkVal({tag, "_pc"}, decPc, e.pc);
`ifdef FETCH_STATS_EN
         checkVal({tag, "_fetchCount"}, fetchCount, expFetch);
         checkVal({tag, "_bubbleCount"}, bubbleCount, expBubble);
`endif
      end
   endtask

   task automatic checkImem(input string tag, input logic rd, input logic [31:0] addr);
      #1;
      checkVal({tag, "_read"}, {31'd0, imemRead}, {31'd0, rd});
      if (rd) checkVal({tag, "_addr"}, imemAddr, addr);
   endtask

   task automatic checkDut2(input string tag, input logic [31:0] pc);
      checkVal({tag, "_valid"}, {31'd0, decValid2}, 32'd1);
      checkVal({tag, "_pc"}, decPc2, pc);
      checkVal({tag, "_ir"}, decIr2, memWord(pc));
   endtask

   task automatic checkResetState(input string tag);
      checkVal({tag, "_valid"}, {31'd0, decValid}, 32'd0);
      checkVal({tag, "_ir"}, decIr, 32'h0000_0013);
      checkVal({tag, "_pc"}, decPc, 32'h0000_0000);
      checkVal({tag, "_read"}, {31'd0, imemRead}, 32'd0);
      checkVal({tag, "_addr"}, imemAddr, 32'h0000_0000);
`ifdef FETCH_STATS_EN
      checkVal({tag, "_fetchCount"}, fetchCount, 32'd0);
      checkVal({tag, "_bubbleCount"}, bubbleCount, 32'd0);
`endif
   endtask

   // Directed sequence; each expectation is queued just before the edge it describes.
   initial begin
      RST = 1'b1; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
      #2;
      checkResetState("reset");
      checkVal("reset_addr2", imemAddr2, 32'hFFFF_FFF8);
      checkVal("reset_read2", {31'd0, imemRead2}, 32'd0);

      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      checkImem("firstFetch", 1'b1, 32'h0);
      expectBubble(1'b0, 32'h0);   tick("edge1");
      expectWord(32'h0, KIND_NEW); tick("wordA");
      checkDut2("wrap0", 32'hFFFF_FFF8);
      expectWord(32'h4, KIND_NEW); tick("wordB");
      checkDut2("wrap1", 32'hFFFF_FFFC);

      STALL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkImem("stallIdle", 1'b0, 32'h0);
         expectWord(32'h4, KIND_HOLD); tick("stallHold");
         if (i == 0) checkDut2("wrap2", 32'h0000_0000);
         if (i == 1) checkDut2("wrap3", 32'h0000_0004);
      end
      STALL = 1'b0;
      checkImem("release", 1'b1, 32'hC);
      expectWord(32'h8, KIND_NEW); tick("wordC");
      expectWord(32'hC, KIND_NEW); tick("wordD");

      REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
      checkImem("redirect", 1'b1, 32'h100);
      expectBubble(1'b1, 32'hC); tick("redirBubble");
      REDIRECT = 1'b0;
      expectWord(32'h100, KIND_NEW); tick("target");
      expectWord(32'h104, KIND_NEW); tick("target4");

      STALL = 1'b1;
      expectWord(32'h104, KIND_HOLD); tick("fillSkid");
      REDIRECT = 1'b1; REDIRECT_PC = 32'h203;
      checkImem("holdRedirect", 1'b1, 32'h200);
      expectBubble(1'b1, 32'h104); tick("holdRedirBubble");
      REDIRECT = 1'b0; STALL = 1'b0;
      expectWord(32'h200, KIND_NEW); tick("target200");
      expectWord(32'h204, KIND_NEW); tick("target204");

      STALL = 1'b1;
      expectWord(32'h204, KIND_HOLD); tick("fillSkid2");
      #2 RST = 1'b1;
      #1;
      checkResetState("midStallReset");
      expFetch = 0; expBubble = 0;
      @(posedge CLK);
      #1 RST = 1'b0; STALL = 1'b0;
      checkImem("restart", 1'b1, 32'h0);
      expectBubble(1'b0, 32'h0);   tick("restartBubble");
      expectWord(32'h0, KIND_NEW); tick("restartA");
      expectWord(32'h4, KIND_NEW); tick("restartB");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
